// File: rtl/loader_pkg.sv
// Shared types and widths for the ROM download loader.
package loader_pkg;

    localparam int DN_ADDR_W = 16;
    localparam int COUNT_W   = 17;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } loader_state_t;

endpackage

// File: rtl/rom_download_loader_if.sv
// HPS ioctl download stream in, core ROM-load write port out.
interface rom_download_loader_if;
    import loader_pkg::*;

    logic                 ioctl_download;
    logic                 ioctl_wr;
    logic [24:0]          ioctl_addr;
    logic [7:0]           ioctl_dout;
    logic [DN_ADDR_W-1:0] dn_addr;
    logic [7:0]           dn_data;
    logic                 dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );

endinterface

// File: rtl/loader_hold_timer.sv
// Loadable down-counter with a zero flag; times the post-load reset stretch.
module loader_hold_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/rom_download_loader.sv
// Sequences ioctl download bytes onto the core ROM-load port and gates core reset.
// Optional image checksum check enabled by defining LOADER_CHECKSUM_EN.
module rom_download_loader
    import loader_pkg::*;
#(
    parameter int unsigned ROM_BYTES   = 36864,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter logic [7:0]  CHECKSUM    = 8'h00
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ext_reset,
    rom_download_loader_if.slave dl,
    output logic                core_reset,
    output logic                load_done,
    output logic                load_error,
    output logic [COUNT_W-1:0]  byte_count
);

    localparam int unsigned        HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [24:0]        ADDR_LIMIT = 25'(ROM_BYTES);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(ROM_BYTES);
    localparam logic [COUNT_W-1:0] COUNT_SAT  = COUNT_W'(65536);

    loader_state_t        state_q, state_d;
    logic                 dl_q;
    logic [DN_ADDR_W-1:0] dn_addr_q;
    logic [7:0]           dn_data_q;
    logic                 dn_wr_q;
    logic                 core_reset_q;
    logic                 load_done_q;
    logic                 load_error_q;
    logic [COUNT_W-1:0]   byte_count_q;

    logic dl_rise, dl_fall, wr_take, in_range, addr_gap, accept;
    logic sum_ok, image_ok, hold_load, hold_zero;

    assign dl_rise  = dl.ioctl_download & ~dl_q;
    assign dl_fall  = ~dl.ioctl_download & dl_q;
    // A strobe coinciding with the falling edge has download low and is dropped here.
    assign wr_take  = (state_q == LOAD) & dl.ioctl_download & dl.ioctl_wr;
    assign in_range = (dl.ioctl_addr < ADDR_LIMIT);
    assign addr_gap = (dl.ioctl_addr != {8'b0, byte_count_q});
    assign accept   = wr_take & in_range;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge CLK) begin
        if (RESET || dl_rise) begin
            sum_q <= 8'h00;
        end else if (accept) begin
            sum_q <= sum_q + dl.ioctl_dout;
        end
    end

    assign sum_ok = (sum_q == CHECKSUM);
`else
    logic unused_checksum;
    assign unused_checksum = ^CHECKSUM;
    assign sum_ok          = 1'b1;
`endif

    assign image_ok = (byte_count_q == COUNT_FULL) & ~load_error_q & sum_ok;

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        if (dl_rise) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (dl_fall) begin
                        if (image_ok) begin
                            state_d   = HOLD;
                            hold_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (hold_zero) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    loader_hold_timer #(
        .WIDTH (HOLD_W)
    ) u_hold_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (hold_load),
        .load_value (HOLD_W'(HOLD_CYCLES - 1)),
        .dec        (state_q == HOLD),
        .zero       (hold_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            // Seen as already high so a download in flight at reset cannot restart
            // the load; a fresh rising edge is required.
            dl_q         <= 1'b1;
            dn_addr_q    <= '0;
            dn_data_q    <= 8'h00;
            dn_wr_q      <= 1'b0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl.ioctl_download;
            dn_wr_q      <= accept;
            core_reset_q <= (state_d == RUN) ? ext_reset : 1'b1;
            if (accept) begin
                dn_addr_q <= dl.ioctl_addr[DN_ADDR_W-1:0];
                dn_data_q <= dl.ioctl_dout;
            end
            if (dl_rise) begin
                byte_count_q <= '0;
                load_error_q <= 1'b0;
                load_done_q  <= 1'b0;
            end else begin
                if (accept && byte_count_q != COUNT_SAT) begin
                    byte_count_q <= byte_count_q + COUNT_W'(1);
                end
                if (wr_take && (!in_range || addr_gap)) begin
                    load_error_q <= 1'b1;
                end
                if (state_q == LOAD && dl_fall && !image_ok) begin
                    load_error_q <= 1'b1;
                end
                if (state_q == HOLD && hold_zero) begin
                    load_done_q <= 1'b1;
                end
            end
        end
    end

    assign dl.dn_addr  = dn_addr_q;
    assign dl.dn_data  = dn_data_q;
    assign dl.dn_wr    = dn_wr_q;
    assign core_reset  = core_reset_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_rom_download_loader.sv
// Bench for rom_download_loader: scenario table, hand sequences and random images vs a model.
module tb_rom_download_loader;
    import loader_pkg::*;

    localparam int unsigned ROM  = 16;
    localparam int unsigned HOLD = 4;
    localparam logic [7:0]  CHK  = 8'h78;

    logic               clk_sys = 1'b0;
    logic               rst;
    logic               ext_reset;
    logic               core_reset;
    logic               load_done;
    logic               load_error;
    logic [COUNT_W-1:0] byte_count;

    rom_download_loader_if bus ();

    rom_download_loader #(
        .ROM_BYTES   (ROM),
        .HOLD_CYCLES (HOLD),
        .CHECKSUM    (CHK)
    ) dut (
        .CLK        (clk_sys),
        .RESET      (rst),
        .ext_reset  (ext_reset),
        .dl         (bus),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .byte_count (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int          gap;
    } byte_t;

    typedef struct {
        string name;
        int    first_n;
        int    seg_lo;
        int    seg_hi;
        int    exp_count;
        bit    exp_err;
        bit    exp_rel;
    } scen_t;

    typedef struct {
        logic ext;
        logic exp_core;
    } ext_vec_t;

    byte_t       img[$];
    logic [23:0] got[$];
    logic [23:0] exp_w[$];
    int          exp_cnt;
    bit          exp_err;
    bit          exp_ok;
    bit          released;
    scen_t       scen[4];
    ext_vec_t    ev[7];
    int          mode;
    int          len;

    always @(negedge clk_sys) begin
        if (bus.dn_wr === 1'b1) got.push_back({bus.dn_addr, bus.dn_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic add_byte(input int a, input logic [7:0] d, input int g);
        img.push_back('{25'(a), d, g});
    endtask

    // Outcome straight from the loading rules: which bytes land, how many, and verdict.
    task automatic run_model();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        exp_w.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        foreach (img[i]) begin
            if (img[i].addr != 25'(exp_cnt)) exp_err = 1'b1;
            if (img[i].addr < 25'(ROM)) begin
                exp_w.push_back({img[i].addr[15:0], img[i].data});
                exp_cnt++;
`ifdef LOADER_CHECKSUM_EN
                sum = sum + img[i].data;
`endif
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_ok = !exp_err && (exp_cnt == int'(ROM));
`ifdef LOADER_CHECKSUM_EN
        if (sum != CHK) exp_ok = 1'b0;
`endif
        if (!exp_ok) exp_err = 1'b1;
    endtask

    task automatic run_download(input string tag, input bit wr_on_fall, input bit ext_in_hold,
                                input int bad_window);
        logic prev_done;
        int   rel_cyc;
        int   lim;
        run_model();
        got.delete();
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b1;
        step();
        check({tag, ".start"}, {core_reset, load_error, load_done, byte_count},
              {1'b1, 1'b0, 1'b0, 17'd0});
        foreach (img[i]) begin
            repeat (img[i].gap) step();
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = img[i].addr;
            bus.ioctl_dout = img[i].data;
            step();
            bus.ioctl_wr = 1'b0;
        end
        bus.ioctl_download = 1'b0;
        if (wr_on_fall) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(exp_cnt % int'(ROM));
            bus.ioctl_dout = 8'hC3;
        end
        prev_done = 1'b0;
        rel_cyc   = 0;
        lim       = exp_ok ? int'(HOLD) + 10 : bad_window;
        for (int c = 1; c <= lim; c++) begin
            step();
            bus.ioctl_wr = 1'b0;
            if (ext_in_hold) ext_reset = (c == 1 || c == 2);
            if (!core_reset) begin
                rel_cyc = c;
                break;
            end
            prev_done = load_done;
        end
        ext_reset = 1'b0;
        released  = (rel_cyc != 0);
        check({tag, ".n_writes"}, got.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < got.size(); k++)
            check({tag, ".write"}, got[k], exp_w[k]);
        check({tag, ".byte_count"}, byte_count, exp_cnt);
        check({tag, ".load_error"}, load_error, exp_err);
        check({tag, ".release_cycle"}, rel_cyc, exp_ok ? int'(HOLD) + 1 : 0);
        if (exp_ok) check({tag, ".done_edge"}, {prev_done, load_done}, 2'b01);
        else check({tag, ".load_done"}, load_done, 1'b0);
    endtask

    task automatic build_scen(input int idx);
        img.delete();
        for (int a = 0; a < scen[idx].first_n; a++) add_byte(a, 8'(a) ^ 8'h5A, 0);
        for (int a = scen[idx].seg_lo; a <= scen[idx].seg_hi; a++) add_byte(a, 8'(a) ^ 8'h5A, 0);
    endtask

    task automatic build_good();
        img.delete();
        for (int a = 0; a < int'(ROM); a++) add_byte(a, 8'(a) ^ 8'h5A, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        scen[0] = '{"short",        15, 0,  -1, 15, 1'b1, 1'b0};
        scen[1] = '{"out_of_range", 16, 16, 16, 16, 1'b1, 1'b0};
        scen[2] = '{"addr_gap",      8, 9,  16, 15, 1'b1, 1'b0};
        scen[3] = '{"good",         16, 0,  -1, 16, 1'b0, 1'b1};
        ev[0] = '{1'b0, 1'b0};
        ev[1] = '{1'b1, 1'b0};
        ev[2] = '{1'b1, 1'b1};
        ev[3] = '{1'b1, 1'b1};
        ev[4] = '{1'b0, 1'b1};
        ev[5] = '{1'b0, 1'b0};
        ev[6] = '{1'b0, 1'b0};

        rst                = 1'b1;
        ext_reset          = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'h00;
        repeat (3) step();
        check("reset.outputs", {bus.dn_wr, core_reset, load_done, load_error, byte_count},
              {1'b0, 1'b1, 1'b0, 1'b0, 17'd0});
        check("reset.dn_bus", {bus.dn_addr, bus.dn_data}, 24'h0);
        rst = 1'b0;
        step();
        check("idle.core_reset", core_reset, 1'b1);

        got.delete();
        for (int i = 0; i < 3; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            step();
        end
        bus.ioctl_wr = 1'b0;
        repeat (2) step();
        check("idle_wr.n_writes", got.size(), 0);
        check("idle_wr.byte_count", byte_count, 0);

        foreach (scen[s]) begin
            build_scen(s);
            run_download(scen[s].name, 1'b0, 1'b0, 1000);
            check({scen[s].name, ".tbl_count"}, byte_count, scen[s].exp_count);
            check({scen[s].name, ".tbl_error"}, load_error, scen[s].exp_err);
            check({scen[s].name, ".tbl_release"}, released, scen[s].exp_rel);
        end

        got.delete();
        for (int i = 0; i < 3; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            step();
        end
        bus.ioctl_wr = 1'b0;
        repeat (2) step();
        check("run_wr.n_writes", got.size(), 0);
        check("run_wr.byte_count", byte_count, ROM);

        foreach (ev[i]) begin
            ext_reset = ev[i].ext;
            check("ext_reset.core_reset", core_reset, ev[i].exp_core);
            step();
        end
        ext_reset = 1'b0;

        bus.ioctl_download = 1'b1;
        step();
        for (int a = 0; a < 8; a++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(a);
            bus.ioctl_dout = 8'(a) ^ 8'h5A;
            step();
        end
        check("mid.count_before", byte_count, 8);
        bus.ioctl_addr = 25'd8;
        rst            = 1'b1;
        step();
        check("mid.outputs", {bus.dn_wr, core_reset, load_done, load_error, byte_count},
              {1'b0, 1'b1, 1'b0, 1'b0, 17'd0});
        check("mid.dn_bus", {bus.dn_addr, bus.dn_data}, 24'h0);
        rst                = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        repeat (3) step();
        check("mid.after", {core_reset, load_done, byte_count}, {1'b1, 1'b0, 17'd0});
        build_good();
        run_download("after_reset", 1'b0, 1'b0, 50);

        build_good();
        run_download("hold_ext", 1'b1, 1'b1, 50);

`ifdef LOADER_CHECKSUM_EN
        build_good();
        img[3].data = img[3].data ^ 8'h10;
        run_download("bad_sum", 1'b0, 1'b0, 100);
        check("bad_sum.error", load_error, 1'b1);
`endif

        for (int t = 0; t < 20; t++) begin
            mode = int'($urandom_range(0, 3));
            len  = (mode == 1) ? int'($urandom_range(12, 18)) : int'(ROM);
            img.delete();
            for (int i = 0; i < len; i++)
                add_byte(i, 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            if (mode == 0 && $urandom_range(0, 1) == 1)
                foreach (img[i]) img[i].data = img[i].addr[7:0] ^ 8'h5A;
            if (mode == 2) img[$urandom_range(0, len - 1)].addr = 25'($urandom_range(0, 20));
            if (mode == 3) add_byte(int'($urandom_range(ROM, ROM + 40)), 8'($urandom), 0);
            run_download($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_download_loader.md
# rom_download_loader

Sequencer between the HPS `ioctl` download stream and the arcade core's `dn_addr`/`dn_data`/`dn_wr` ROM-load port. It bounds-checks and re-times each download byte, counts bytes and checks address continuity. It holds the core in reset during a download and for a fixed stretch afterwards. It releases the core only after a complete, valid image has been received.

## Interface
Parameters:
- `ROM_BYTES`, 36864: exact image length in bytes; the legal address range is 0..ROM_BYTES-1, and ROM_BYTES must be ≤ 65536.
- `HOLD_CYCLES`, 1024: number of CLK cycles `core_reset` stays high after a good download; must be ≥ 1.
- `CHECKSUM`, 8'h00: expected 8-bit additive sum of the image. Used only with `LOADER_CHECKSUM_EN`.

Ports:
- `CLK` in 1: system clock (`clk_sys`).
- `RESET` in 1: synchronous, active-high.
- `ext_reset` in 1: OR of the user/OSD reset requests.
- `ioctl_download` in 1: high for the whole download.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `dn_addr` out 16: core ROM write address.
- `dn_data` out 8: core ROM write data.
- `dn_wr` out 1: core ROM write strobe.
- `core_reset` out 1: reset to the core.
- `load_done` out 1: a valid image is resident.
- `load_error` out 1: the last download was bad. Sticky until the next download starts.
- `byte_count` out 17: number of bytes accepted in the current or last download.

## Operation
- States:
  - IDLE: no valid image; `core_reset`=1.
  - LOAD: download in progress; `core_reset`=1.
  - HOLD: post-load reset stretch; `core_reset`=1.
  - RUN: `core_reset`=`ext_reset`.
- Reset values: state=IDLE, `dn_addr`=0, `dn_data`=0, `dn_wr`=0, `core_reset`=1, `load_done`=0, `load_error`=0, `byte_count`=0, hold counter=0.
- Rising edge of `ioctl_download`, from any state:
  - Go to LOAD.
  - Clear `byte_count`, `load_error` and `load_done`.
- In LOAD, each cycle with `ioctl_wr`=1:
  - If `ioctl_addr` < ROM_BYTES: register `dn_addr`=`ioctl_addr[15:0]`, `dn_data`=`ioctl_dout`, and pulse `dn_wr`. Increment `byte_count`, saturating at 65536.
  - If `ioctl_addr` ≥ ROM_BYTES: drop the byte, set `load_error`, and do not count it.
  - Continuity check: if `ioctl_addr` ≠ `byte_count` (value before increment), set `load_error`. An in-range byte is still written.
- Falling edge of `ioctl_download` in LOAD:
  - If `byte_count` = ROM_BYTES and `load_error`=0: go to HOLD and load the hold counter with HOLD_CYCLES-1.
  - Otherwise: set `load_error` and go to IDLE. The core stays in reset indefinitely.
- HOLD:
  - Decrement the counter each cycle.
  - When the counter is 0: go to RUN and set `load_done`=1.
  - `ext_reset` during HOLD is ignored; the counter is not restarted.
- RUN: `core_reset` follows `ext_reset` combinationally through one register (one-cycle delay).
- `ioctl_wr` outside LOAD is ignored: no `dn_wr`, no count.
- `ioctl_wr` on the same cycle as the falling edge of `ioctl_download` is ignored.
- `RESET` mid-operation: return to IDLE immediately. A partial image is treated as invalid and a new download is required.

## Timing
- `dn_wr`, `dn_addr` and `dn_data` are registered. `dn_wr` is high exactly one cycle, one cycle after the accepted `ioctl_wr` cycle.
- Back-to-back `ioctl_wr` cycles give back-to-back `dn_wr` pulses; throughput is one byte per cycle.
- `core_reset` is registered:
  - It rises one cycle after the rising edge of `ioctl_download`.
  - It falls HOLD_CYCLES+1 cycles after the falling edge of `ioctl_download` on a good load.
- `load_done` rises on the same cycle `core_reset` first falls.
- `load_error` is set one cycle after the offending `ioctl_wr` or falling edge.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Maintain an 8-bit wrapping sum of accepted bytes, cleared at download start.
  - At the falling edge, a sum ≠ CHECKSUM counts as an error: `load_error`=1 and the state goes to IDLE.
- `LOADER_CHECKSUM_EN` undefined:
  - No sum register.
  - The CHECKSUM parameter is unused.
  - Validity is determined by length and address checks only.

## Structure
- Shared package `loader_pkg` contains:
  - The state enum `loader_state_t` {IDLE, LOAD, HOLD, RUN}.
  - `DN_ADDR_W`=16 and `COUNT_W`=17.
- One sub-module, `loader_hold_timer`: a loadable down-counter with a zero flag, used for HOLD. The sequencer's state machine and datapath are flat in `rom_download_loader`.

## Test plan
- Good load: ROM_BYTES=16, HOLD_CYCLES=4. Download addresses 0..15 with data = addr ^ 8'h5A → 16 `dn_wr` pulses with matching addr/data; `core_reset` falls 5 cycles after the download falls; `load_done`=1, `load_error`=0.
- Short image: 15 bytes → `load_error`=1, state IDLE, `core_reset` stays 1 for ≥ 1000 cycles, `byte_count`=15.
- Out of range: 16 good bytes plus addr 16 → no `dn_wr` for addr 16; `load_error`=1; core not released.
- Address gap: addresses 0..7, 9..16 with ROM_BYTES=16 → error on addr 9; addr 16 is dropped; `core_reset` stays high.
- Reset handling:
  - `RESET` at byte 8 of a download → immediately IDLE with all outputs at reset values.
  - A following good load completes normally.
  - In RUN, `ext_reset` pulsed for 3 cycles → `core_reset` high for exactly 3 cycles, delayed by 1 cycle.
- With `LOADER_CHECKSUM_EN`, CHECKSUM=8'h78: the good image passes; flipping one data bit → `load_error`=1.
